perceptron_uart_loader: RTL



---
 rtl/perceptron_pkg.sv | 25 ++
 rtl/perceptron_uart_loader_if.sv | 21 ++
 rtl/perceptron_uart_loader_tx.sv | 38 +++
 rtl/perceptron_uart_loader.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/perceptron_pkg.sv
// Shared definitions for the perceptron UART loader: word format,
// host command bytes and the loader FSM encoding.
package perceptron_pkg;

   localparam int WORD_W = 16;   // Q4.12 raw two's-complement word
   localparam int FRAC_W = 12;

   localparam logic [7:0] CMD_W = 8'h57;   // 'W' load both weights
   localparam logic [7:0] CMD_I = 8'h49;   // 'I' set inputs, return result
   localparam logic [7:0] CMD_R = 8'h52;   // 'R' read back weights

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_RX_PAYLOAD = 3'd1,
      ST_LOAD       = 3'd2,
      ST_SETTLE     = 3'd3,
      ST_TX         = 3'd4
   } state_t;

   // Whole-number value to Q4.12 bit pattern (wraps outside -8..7).
   function automatic logic [WORD_W-1:0] to_q(input int whole);
      return WORD_W'(whole <<< FRAC_W);
   endfunction

endpackage

// File: rtl/perceptron_uart_loader_if.sv
// Byte-level UART side of the loader: receive strobe plus transmit
// valid/ready handshake. master = host/UART side, slave = loader.
interface perceptron_uart_loader_if;

   logic [7:0] rx_data;
   logic       rx_valid;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;

   modport master (
      output rx_data, rx_valid, tx_ready,
      input  tx_data, tx_valid
   );

   modport slave (
      input  rx_data, rx_valid, tx_ready,
      output tx_data, tx_valid
   );

endinterface

// File: rtl/perceptron_uart_loader_tx.sv
// Response byte serializer: holds up to four bytes, presents them MSB
// byte first and advances one byte per accepted transfer.
module perceptron_uart_loader_tx (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic [31:0] load_word,
   input  logic [2:0]  load_cnt,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        done
);

   logic [31:0] buffer;
   logic [2:0]  left;
   logic        xfer;

   assign tx_valid = (left != 3'd0);
   assign tx_data  = buffer[31:24];
   assign xfer     = tx_valid && tx_ready;
   assign done     = xfer && (left == 3'd1);

   // Load a new response or shift the next byte up after each accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buffer <= '0;
         left   <= '0;
      end else if (load) begin
         buffer <= load_word;
         left   <= load_cnt;
      end else if (xfer) begin
         buffer <= {buffer[23:0], 8'h00};
         left   <= left - 3'd1;
      end
   end

endmodule

// File: rtl/perceptron_uart_loader.sv
// Host command decoder between the UART byte stream and the perceptron:
// assembles big-endian Q4.12 words, loads weights, drives inputs and
// returns the classification or a weight readback.
module perceptron_uart_loader
   import perceptron_pkg::*;
#(
   parameter int SETTLE_CYCLES  = 4,
   parameter int TIMEOUT_CYCLES = 120000,
   parameter int CNT_W          = 17
) (
   input  logic                    clk,
   input  logic                    rst_n,
   perceptron_uart_loader_if.slave uart,
   output logic [WORD_W-1:0]       weight1_new,
   output logic [WORD_W-1:0]       weight2_new,
   output logic                    weight1_ld,
   output logic                    weight2_ld,
   input  logic [WORD_W-1:0]       weight1,
   input  logic [WORD_W-1:0]       weight2,
   output logic [WORD_W-1:0]       IN1,
   output logic [WORD_W-1:0]       IN2,
   input  logic                    result,
   output logic                    busy,
   output logic                    frame_err
);

   localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t           state, state_nxt;
   logic             is_w;        // current frame is a weight load
   logic [1:0]       bcnt;        // payload bytes already taken
   logic [23:0]      asm_q;       // first three payload bytes
   logic [CNT_W-1:0] cnt;         // idle timeout / settle counter
   logic [31:0]      frame;
   logic             last_byte;
   logic             tx_load, tx_done;
   logic [31:0]      tx_word;
   logic [2:0]       tx_cnt;
   logic             abort, overrun, ld;

   assign frame     = {asm_q, uart.rx_data};
   assign last_byte = (state == ST_RX_PAYLOAD) && uart.rx_valid && (bcnt == 2'd3);

   assign weight1_ld = ld;
   assign weight2_ld = ld;
   assign busy       = (state != ST_IDLE);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // Next state, serializer loads, load strobe and error conditions.
   always_comb begin
      state_nxt = state;
      tx_load   = 1'b0;
      tx_word   = '0;
      tx_cnt    = '0;
      abort     = 1'b0;
      overrun   = 1'b0;
      ld        = 1'b0;
      case (state)
         ST_IDLE: begin
            if (uart.rx_valid) begin
               if (uart.rx_data == CMD_W || uart.rx_data == CMD_I) begin
                  state_nxt = ST_RX_PAYLOAD;
               end else if (uart.rx_data == CMD_R) begin
                  // weights are snapshotted into the serializer right here
                  state_nxt = ST_TX;
                  tx_load   = 1'b1;
                  tx_word   = {weight1, weight2};
                  tx_cnt    = 3'd4;
               end
            end
         end
         ST_RX_PAYLOAD: begin
            if (last_byte) begin
               state_nxt = is_w ? ST_LOAD : ST_SETTLE;
            end else if (!uart.rx_valid && cnt == TIMEOUT_LAST) begin
               abort     = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         ST_LOAD: begin
            ld        = 1'b1;
            overrun   = uart.rx_valid;
            state_nxt = ST_IDLE;
         end
         ST_SETTLE: begin
            overrun = uart.rx_valid;
            if (cnt == SETTLE_LAST) begin
               state_nxt = ST_TX;
               tx_load   = 1'b1;
               tx_word   = {7'b0, result, 24'b0};
               tx_cnt    = 3'd1;
            end
         end
         ST_TX: begin
            overrun = uart.rx_valid;
            if (tx_done) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Shared counter: idle gap in RX_PAYLOAD, elapsed cycles in SETTLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (state_nxt != state) begin
         cnt <= '0;
      end else if (state == ST_RX_PAYLOAD && uart.rx_valid) begin
         cnt <= '0;
      end else if (state == ST_RX_PAYLOAD || state == ST_SETTLE) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   // Frame assembly and the held output words; partial frames never
   // touch weight_new or IN1/IN2 because those only load on the 4th byte.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         is_w        <= 1'b0;
         bcnt        <= '0;
         asm_q       <= '0;
         weight1_new <= '0;
         weight2_new <= '0;
         IN1         <= '0;
         IN2         <= '0;
         frame_err   <= 1'b0;
      end else begin
         if (state == ST_IDLE && uart.rx_valid) is_w <= (uart.rx_data == CMD_W);
         if (state != ST_RX_PAYLOAD)  bcnt <= '0;
         else if (uart.rx_valid)      bcnt <= bcnt + 2'd1;
         if (state == ST_RX_PAYLOAD && uart.rx_valid) asm_q <= frame[23:0];
         if (last_byte && is_w)  {weight1_new, weight2_new} <= frame;
         if (last_byte && !is_w) {IN1, IN2} <= frame;
         frame_err <= abort | overrun;
      end
   end

   perceptron_uart_loader_tx u_tx (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (tx_load),
      .load_word (tx_word),
      .load_cnt  (tx_cnt),
      .tx_data   (uart.tx_data),
      .tx_valid  (uart.tx_valid),
      .tx_ready  (uart.tx_ready),
      .done      (tx_done)
   );

endmodule
